// File: rtl/rs_age_multicdb.sv
// rs_age_multicdb: reservation station with NUM_CDB parallel wakeup ports, an
// age-matrix oldest-ready select and a registered valid/ready issue stage.
// Optional macro RS_OCCUPANCY_EN adds the occupancy / almost_full outputs.
module rs_age_multicdb #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 3,
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned NUM_CDB     = 2,
  parameter int unsigned OP_WIDTH    = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [DATA_WIDTH-1:0]           src1_val,
  input  logic [DATA_WIDTH-1:0]           src2_val,
  input  logic [DATA_WIDTH-1:0]           src3_val,
  input  logic [TAG_WIDTH-1:0]            src1_tag,
  input  logic [TAG_WIDTH-1:0]            src2_tag,
  input  logic [TAG_WIDTH-1:0]            src3_tag,
  input  logic                            src1_rdy,
  input  logic                            src2_rdy,
  input  logic                            src3_rdy,
  input  logic [OP_WIDTH-1:0]             disp_opcode,
  input  logic [4:0]                      disp_dest_reg,
  input  logic [TAG_WIDTH-1:0]            disp_rob_tag,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]   cdb_value,
  output logic                            fu_valid,
  input  logic                            fu_ready,
  output logic [DATA_WIDTH-1:0]           fu_op1,
  output logic [DATA_WIDTH-1:0]           fu_op2,
  output logic [DATA_WIDTH-1:0]           fu_op3,
  output logic [OP_WIDTH-1:0]             fu_opcode,
  output logic [TAG_WIDTH-1:0]            fu_dest_tag,
  output logic [4:0]                      fu_dest_reg
`ifdef RS_OCCUPANCY_EN
  ,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy,
  output logic                            almost_full
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned REG_W = 5;

  // Entry storage
  logic [NUM_ENTRIES-1:0]  busy_q, busy_d;
  logic [2:0]              rdy_q  [NUM_ENTRIES];
  logic [2:0]              rdy_d  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]   val_q  [NUM_ENTRIES][3];
  logic [DATA_WIDTH-1:0]   val_d  [NUM_ENTRIES][3];
  logic [TAG_WIDTH-1:0]    tag_q  [NUM_ENTRIES][3];
  logic [TAG_WIDTH-1:0]    tag_d  [NUM_ENTRIES][3];
  logic [OP_WIDTH-1:0]     op_q   [NUM_ENTRIES];
  logic [OP_WIDTH-1:0]     op_d   [NUM_ENTRIES];
  logic [REG_W-1:0]        dreg_q [NUM_ENTRIES];
  logic [REG_W-1:0]        dreg_d [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]    rob_q  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]    rob_d  [NUM_ENTRIES];
  // elder_q[j][i] set: entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] elder_q, elder_d;

  // Output stage
  logic                    fu_valid_q, fu_valid_d;
  logic [DATA_WIDTH-1:0]   fu_op_q [3];
  logic [DATA_WIDTH-1:0]   fu_op_d [3];
  logic [OP_WIDTH-1:0]     fu_opc_q, fu_opc_d;
  logic [TAG_WIDTH-1:0]    fu_tag_q, fu_tag_d;
  logic [REG_W-1:0]        fu_reg_q, fu_reg_d;

  logic [DATA_WIDTH-1:0]   src_val [3];
  logic [TAG_WIDTH-1:0]    src_tag [3];
  logic [2:0]              src_rdy;
  logic [NUM_ENTRIES-1:0]  ready_vec;
  logic [IDX_W-1:0]        sel_idx, alloc_idx;
  logic                    disp_fire, issue_load;
  logic [DATA_WIDTH:0]     lk;

  assign src_val[0] = src1_val;
  assign src_val[1] = src2_val;
  assign src_val[2] = src3_val;
  assign src_tag[0] = src1_tag;
  assign src_tag[1] = src2_tag;
  assign src_tag[2] = src3_tag;
  assign src_rdy    = {src3_rdy, src2_rdy, src1_rdy};

  // Returns {hit, value}; scanning high to low lets the lowest port win
  function automatic logic [DATA_WIDTH:0] cdb_lookup(
    input logic [TAG_WIDTH-1:0]          tag,
    input logic [NUM_CDB-1:0]            vld,
    input logic [NUM_CDB*TAG_WIDTH-1:0]  tags,
    input logic [NUM_CDB*DATA_WIDTH-1:0] vals
  );
    logic [DATA_WIDTH:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        res = {1'b1, vals[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    return res;
  endfunction

  assign disp_ready = ~&busy_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_load = !flush && (!fu_valid_q || fu_ready) && (|ready_vec);

  // Ready flags, lowest free slot and oldest ready entry
  always_comb begin
    ready_vec = '0;
    alloc_idx = '0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = busy_q[i] && rdy_q[i][0] && rdy_q[i][1] &&
                     (rdy_q[i][2] || (NUM_SRC == 2));
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
      if (ready_vec[i] && ((ready_vec & elder_q[i]) == '0)) sel_idx = IDX_W'(i);
    end
  end

  // Next state: wakeup, issue, dispatch, then flush overriding everything
  always_comb begin
    busy_d     = busy_q;
    rdy_d      = rdy_q;
    val_d      = val_q;
    tag_d      = tag_q;
    op_d       = op_q;
    dreg_d     = dreg_q;
    rob_d      = rob_q;
    elder_d    = elder_q;
    fu_valid_d = fu_valid_q;
    fu_op_d    = fu_op_q;
    fu_opc_d   = fu_opc_q;
    fu_tag_d   = fu_tag_q;
    fu_reg_d   = fu_reg_q;
    lk         = '0;

    for (int e = 0; e < NUM_ENTRIES; e++) begin
      for (int s = 0; s < 3; s++) begin
        if (busy_q[e] && !rdy_q[e][s]) begin
          lk = cdb_lookup(tag_q[e][s], cdb_valid, cdb_tag, cdb_value);
          if (lk[DATA_WIDTH]) begin
            rdy_d[e][s] = 1'b1;
            val_d[e][s] = lk[DATA_WIDTH-1:0];
          end
        end
      end
    end

    if (issue_load) begin
      busy_d[sel_idx] = 1'b0;
      fu_valid_d      = 1'b1;
      for (int s = 0; s < 3; s++) fu_op_d[s] = val_q[sel_idx][s];
      fu_opc_d = op_q[sel_idx];
      fu_tag_d = rob_q[sel_idx];
      fu_reg_d = dreg_q[sel_idx];
    end else if (fu_ready) begin
      fu_valid_d = 1'b0;
    end

    if (disp_fire) begin
      busy_d[alloc_idx] = 1'b1;
      for (int s = 0; s < 3; s++) begin
        tag_d[alloc_idx][s] = src_tag[s];
        if ((s == 2) && (NUM_SRC == 2)) begin
          rdy_d[alloc_idx][s] = 1'b1;
          val_d[alloc_idx][s] = '0;
          tag_d[alloc_idx][s] = '0;
        end else if (src_rdy[s]) begin
          rdy_d[alloc_idx][s] = 1'b1;
          val_d[alloc_idx][s] = src_val[s];
        end else begin
          lk = cdb_lookup(src_tag[s], cdb_valid, cdb_tag, cdb_value);
          rdy_d[alloc_idx][s] = lk[DATA_WIDTH];
          val_d[alloc_idx][s] = lk[DATA_WIDTH-1:0];
        end
      end
      op_d[alloc_idx]   = disp_opcode;
      dreg_d[alloc_idx] = disp_dest_reg;
      rob_d[alloc_idx]  = disp_rob_tag;
      // New entry is younger than every busy entry
      for (int j = 0; j < NUM_ENTRIES; j++) elder_d[j][alloc_idx] = 1'b0;
      elder_d[alloc_idx] = busy_q;
    end

    if (flush) begin
      busy_d     = '0;
      elder_d    = '0;
      fu_valid_d = 1'b0;
      for (int e = 0; e < NUM_ENTRIES; e++) rdy_d[e] = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      elder_q    <= '0;
      fu_valid_q <= 1'b0;
      fu_opc_q   <= '0;
      fu_tag_q   <= '0;
      fu_reg_q   <= '0;
      for (int s = 0; s < 3; s++) fu_op_q[s] <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        rdy_q[e]  <= '0;
        op_q[e]   <= '0;
        dreg_q[e] <= '0;
        rob_q[e]  <= '0;
        for (int s = 0; s < 3; s++) begin
          val_q[e][s] <= '0;
          tag_q[e][s] <= '0;
        end
      end
    end else begin
      busy_q     <= busy_d;
      elder_q    <= elder_d;
      fu_valid_q <= fu_valid_d;
      fu_op_q    <= fu_op_d;
      fu_opc_q   <= fu_opc_d;
      fu_tag_q   <= fu_tag_d;
      fu_reg_q   <= fu_reg_d;
      rdy_q      <= rdy_d;
      val_q      <= val_d;
      tag_q      <= tag_d;
      op_q       <= op_d;
      dreg_q     <= dreg_d;
      rob_q      <= rob_d;
    end
  end

  assign fu_valid    = fu_valid_q;
  assign fu_op1      = fu_op_q[0];
  assign fu_op2      = fu_op_q[1];
  assign fu_op3      = fu_op_q[2];
  assign fu_opcode   = fu_opc_q;
  assign fu_dest_tag = fu_tag_q;
  assign fu_dest_reg = fu_reg_q;

`ifdef RS_OCCUPANCY_EN
  logic [CNT_W-1:0] occ_q, occ_d;

  // Busy-entry count tracking dispatch, issue and flush
  always_comb begin
    occ_d = occ_q + CNT_W'(disp_fire) - CNT_W'(issue_load);
    if (flush) occ_d = '0;
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy   = occ_q;
  assign almost_full = (occ_q >= CNT_W'(NUM_ENTRIES - 1));
`endif

endmodule

// File: tb/tb_rs_age_multicdb.sv
// Bench for rs_age_multicdb: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations (second instance: NUM_SRC=2).
module tb_rs_age_multicdb;

  localparam int NE = 4;

  logic        clk, rst_n, flush, disp_valid, disp_ready;
  logic [31:0] src1_val, src2_val, src3_val;
  logic [2:0]  src1_tag, src2_tag, src3_tag;
  logic        src1_rdy, src2_rdy, src3_rdy;
  logic [4:0]  disp_opcode, disp_dest_reg;
  logic [2:0]  disp_rob_tag;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        fu_valid, fu_ready;
  logic [31:0] fu_op1, fu_op2, fu_op3;
  logic [4:0]  fu_opcode, fu_dest_reg;
  logic [2:0]  fu_dest_tag;

  // Second instance (two-source build)
  logic        b_disp_valid, b_disp_ready;
  logic [31:0] b_s1v;
  logic [2:0]  b_s2t, b_s3t, b_rob;
  logic        b_s1r, b_s2r, b_s3r;
  logic [1:0]  b_cdb_valid;
  logic [5:0]  b_cdb_tag;
  logic [63:0] b_cdb_value;
  logic        b_fu_valid;
  logic [31:0] b_fu_op1, b_fu_op2, b_fu_op3;
  logic [4:0]  b_fu_opcode, b_fu_dest_reg;
  logic [2:0]  b_fu_dest_tag;

`ifdef RS_OCCUPANCY_EN
  logic [2:0] occupancy, b_occupancy;
  logic       almost_full, b_almost_full;
`endif

  int checks = 0;
  int errors = 0;

  rs_age_multicdb u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .src1_val(src1_val), .src2_val(src2_val), .src3_val(src3_val),
    .src1_tag(src1_tag), .src2_tag(src2_tag), .src3_tag(src3_tag),
    .src1_rdy(src1_rdy), .src2_rdy(src2_rdy), .src3_rdy(src3_rdy),
    .disp_opcode(disp_opcode), .disp_dest_reg(disp_dest_reg), .disp_rob_tag(disp_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_op1(fu_op1), .fu_op2(fu_op2), .fu_op3(fu_op3),
    .fu_opcode(fu_opcode), .fu_dest_tag(fu_dest_tag), .fu_dest_reg(fu_dest_reg)
`ifdef RS_OCCUPANCY_EN
    , .occupancy(occupancy), .almost_full(almost_full)
`endif
  );

  rs_age_multicdb #(.NUM_SRC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .disp_valid(b_disp_valid), .disp_ready(b_disp_ready),
    .src1_val(b_s1v), .src2_val(32'd0), .src3_val(32'hdead),
    .src1_tag(3'd0), .src2_tag(b_s2t), .src3_tag(b_s3t),
    .src1_rdy(b_s1r), .src2_rdy(b_s2r), .src3_rdy(b_s3r),
    .disp_opcode(5'd9), .disp_dest_reg(5'd30), .disp_rob_tag(b_rob),
    .cdb_valid(b_cdb_valid), .cdb_tag(b_cdb_tag), .cdb_value(b_cdb_value),
    .fu_valid(b_fu_valid), .fu_ready(1'b1),
    .fu_op1(b_fu_op1), .fu_op2(b_fu_op2), .fu_op3(b_fu_op3),
    .fu_opcode(b_fu_opcode), .fu_dest_tag(b_fu_dest_tag), .fu_dest_reg(b_fu_dest_reg)
`ifdef RS_OCCUPANCY_EN
    , .occupancy(b_occupancy), .almost_full(b_almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]       r;
    logic [2:0][31:0] v;
    logic [2:0][2:0]  t;
    logic [4:0]       op;
    logic [4:0]       dreg;
    logic [2:0]       rob;
  } ent_t;

  ent_t        mq[$];          // busy entries in dispatch order
  logic        m_fv;
  logic [31:0] m_op1, m_op2, m_op3;
  logic [4:0]  m_opc, m_reg;
  logic [2:0]  m_tag;

  function automatic logic [32:0] lookup(input logic [2:0] tag);
    for (int k = 0; k < 2; k++)
      if (cdb_valid[k] && (cdb_tag[k*3 +: 3] == tag)) return {1'b1, cdb_value[k*32 +: 32]};
    return 33'd0;
  endfunction

  always @(posedge clk) begin : model
    ent_t        e;
    int          sel;
    logic        fire;
    logic [32:0] hit;
    if (!rst_n) begin
      mq.delete();
      m_fv = 1'b0; m_op1 = '0; m_op2 = '0; m_op3 = '0;
      m_opc = '0; m_reg = '0; m_tag = '0;
    end else begin
      sel = -1;
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (sel < 0 && (&e.r)) sel = i;
      end
      fire = disp_valid && (mq.size() < NE) && !flush;
      if (flush) begin
        mq.delete();
        m_fv = 1'b0;
      end else begin
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          for (int s = 0; s < 3; s++) begin
            hit = lookup(e.t[s]);
            if (!e.r[s] && hit[32]) begin e.r[s] = 1'b1; e.v[s] = hit[31:0]; end
          end
          mq[i] = e;
        end
        if ((!m_fv || fu_ready) && sel >= 0) begin
          e = mq[sel];
          m_fv = 1'b1; m_op1 = e.v[0]; m_op2 = e.v[1]; m_op3 = e.v[2];
          m_opc = e.op; m_reg = e.dreg; m_tag = e.rob;
          mq.delete(sel);
        end else if (fu_ready) begin
          m_fv = 1'b0;
        end
        if (fire) begin
          e.r = {src3_rdy, src2_rdy, src1_rdy};
          e.v = {src3_val, src2_val, src1_val};
          e.t = {src3_tag, src2_tag, src1_tag};
          for (int s = 0; s < 3; s++) begin
            hit = lookup(e.t[s]);
            if (!e.r[s] && hit[32]) begin e.r[s] = 1'b1; e.v[s] = hit[31:0]; end
          end
          e.op = disp_opcode; e.dreg = disp_dest_reg; e.rob = disp_rob_tag;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fu_valid", 32'(fu_valid), 32'(m_fv));
      chk("disp_ready", 32'(disp_ready), 32'(mq.size() < NE));
`ifdef RS_OCCUPANCY_EN
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
`endif
      if (m_fv) begin
        chk("fu_op1", fu_op1, m_op1);
        chk("fu_op2", fu_op2, m_op2);
        chk("fu_op3", fu_op3, m_op3);
        chk("fu_opcode", 32'(fu_opcode), 32'(m_opc));
        chk("fu_dest_tag", 32'(fu_dest_tag), 32'(m_tag));
        chk("fu_dest_reg", 32'(fu_dest_reg), 32'(m_reg));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic set_cdb(input int k, input logic [2:0] t, input logic [31:0] v);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*3 +: 3] = t;
    cdb_value[k*32 +: 32] = v;
  endtask

  task automatic disp(input logic [2:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] v3, input logic [2:0] rdy, input logic [2:0] t1,
                      input logic [2:0] t2, input logic [4:0] op, input logic [4:0] dreg);
    disp_valid = 1'b1; disp_rob_tag = rob;
    src1_val = v1; src2_val = v2; src3_val = v3;
    {src3_rdy, src2_rdy, src1_rdy} = rdy;
    src1_tag = t1; src2_tag = t2; src3_tag = 3'd0;
    disp_opcode = op; disp_dest_reg = dreg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fu_ready = 1'b0;
    idle();
    disp(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    disp_valid = 1'b0;
    b_disp_valid = 1'b0; b_s1v = '0; b_s2t = '0; b_s3t = '0; b_rob = '0;
    b_s1r = 1'b0; b_s2r = 1'b0; b_s3r = 1'b0;
    b_cdb_valid = '0; b_cdb_tag = '0; b_cdb_value = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_fu_valid", 32'(fu_valid), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_fu_op1", fu_op1, 32'd0);
    chk("rst_fu_dest_tag", 32'(fu_dest_tag), 32'd0);
    chk("rst_b_fu_valid", 32'(b_fu_valid), 32'd0);
    rst_n = 1'b1;

    // A: all ready, two-edge latency
    fu_ready = 1'b1;
    disp(1, 5, 7, 0, 3'b111, 0, 0, 5'd3, 5'd10);
    tick(); idle();
    chk("a_lat1_valid", 32'(fu_valid), 32'd0);
    tick();
    chk("a_valid", 32'(fu_valid), 32'd1);
    chk("a_op1", fu_op1, 32'd5);
    chk("a_op2", fu_op2, 32'd7);
    chk("a_tag", 32'(fu_dest_tag), 32'd1);
    tick();
    chk("a_drain", 32'(fu_valid), 32'd0);

    // B/C: out-of-order wakeup on different CDB ports
    disp(2, 0, 2, 3, 3'b110, 4, 0, 5'd1, 5'd11);
    tick();
    disp(3, 0, 2, 3, 3'b110, 5, 0, 5'd2, 5'd12);
    tick(); idle();
    set_cdb(1, 5, 32'h55);
    tick(); idle();
    chk("c_wake_not_yet", 32'(fu_valid), 32'd0);
    set_cdb(0, 4, 32'h44);
    tick(); idle();
    chk("c_valid", 32'(fu_valid), 32'd1);
    chk("c_op1", fu_op1, 32'h55);
    chk("c_tag", 32'(fu_dest_tag), 32'd3);
    tick();
    chk("b_op1", fu_op1, 32'h44);
    chk("b_tag", 32'(fu_dest_tag), 32'd2);
    tick();
    chk("bc_drain", 32'(fu_valid), 32'd0);

    // Dual CDB capture in the dispatch cycle
    disp(4, 0, 0, 9, 3'b100, 6, 7, 5'd4, 5'd13);
    set_cdb(0, 6, 32'h10);
    set_cdb(1, 7, 32'h20);
    tick(); idle();
    tick();
    chk("dual_valid", 32'(fu_valid), 32'd1);
    chk("dual_op1", fu_op1, 32'h10);
    chk("dual_op2", fu_op2, 32'h20);
    chk("dual_tag", 32'(fu_dest_tag), 32'd4);
    tick();

    // Fill with FU stalled, then drain oldest-first
    fu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(3'(i + 1), 32'h100 + i, 32'h200 + i, 32'h300 + i, 3'b111, 0, 0, 5'(i), 5'(20 + i));
      tick();
    end
    idle();
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_fu_valid", 32'(fu_valid), 32'd1);
    chk("full_tag", 32'(fu_dest_tag), 32'd1);
    disp(7, 1, 1, 1, 3'b111, 0, 0, 5'd7, 5'd7);
    tick(); idle();
    chk("stall_disp_ready", 32'(disp_ready), 32'd0);
    chk("stall_op1", fu_op1, 32'h100);
    tick();
    chk("stall_tag", 32'(fu_dest_tag), 32'd1);
    fu_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("drain_tag", 32'(fu_dest_tag), 32'(i + 1));
      chk("drain_op1", fu_op1, 32'h100 + 32'(i));
      if (i == 1) chk("drain_disp_ready", 32'(disp_ready), 32'd1);
    end
    tick();
    chk("drain_done", 32'(fu_valid), 32'd0);

    // Flush with three busy entries, a full output stage and a dispatch
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(3'(i), 32'h400 + i, 0, 0, 3'b111, 0, 0, 5'd5, 5'd1);
      tick();
    end
    idle();
    chk("pre_flush_valid", 32'(fu_valid), 32'd1);
    flush = 1'b1;
    disp(6, 1, 1, 1, 3'b111, 0, 0, 5'd6, 5'd6);
    tick(); idle();
    chk("flush_valid", 32'(fu_valid), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd1);
    fu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_flush_valid", 32'(fu_valid), 32'd0);
    end

    // Two-source build: src3 unready with an unmatched tag is ignored
    b_disp_valid = 1'b1; b_rob = 3'd5;
    b_s1v = 32'h11; b_s1r = 1'b1;
    b_s2t = 3'd2;   b_s2r = 1'b0;
    b_s3t = 3'd5;   b_s3r = 1'b0;
    tick();
    b_disp_valid = 1'b0;
    chk("ns2_wait", 32'(b_fu_valid), 32'd0);
    b_cdb_valid = 2'b01; b_cdb_tag = 6'd2; b_cdb_value = 64'h22;
    tick();
    b_cdb_valid = '0;
    chk("ns2_wake_not_yet", 32'(b_fu_valid), 32'd0);
    tick();
    chk("ns2_valid", 32'(b_fu_valid), 32'd1);
    chk("ns2_op1", b_fu_op1, 32'h11);
    chk("ns2_op2", b_fu_op2, 32'h22);
    chk("ns2_tag", 32'(b_fu_dest_tag), 32'd5);
    tick();
    chk("ns2_drain", 32'(b_fu_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_age_multicdb.md
Name: rs_age_multicdb

Overview:
- Parametrised successor of the single-CDB reservation station; sits between the dispatcher and one functional unit (integer, FP or FMA).
- Holds up to NUM_ENTRIES instructions with 2 or 3 source operands.
- Snoops NUM_CDB result buses in parallel, including in the dispatch cycle.
- Issues the oldest ready entry through a registered valid/ready output stage; supports a full pipeline flush.

Parameters:
- DATA_WIDTH, 32, operand width.
- TAG_WIDTH, 3, ROB tag width.
- NUM_ENTRIES, 4, entry count; any value 2..16.
- NUM_SRC, 3, sources used, 2 or 3. When 2, src3 inputs are ignored and operand 3 is treated as ready.
- NUM_CDB, 2, number of CDB ports, 1..4.
- OP_WIDTH, 5, opcode width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash all entries and the output stage.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  equals !full, from registered busy bits.
- src1_val/src2_val/src3_val  in  DATA_WIDTH  operand values.
- src1_tag/src2_tag/src3_tag  in  TAG_WIDTH  producer tags.
- src1_rdy/src2_rdy/src3_rdy  in  1  value valid.
- disp_opcode  in  OP_WIDTH  operation.
- disp_dest_reg  in  5  architectural destination.
- disp_rob_tag  in  TAG_WIDTH  ROB tag of the instruction.
- cdb_valid  in  NUM_CDB  per-port valid.
- cdb_tag  in  NUM_CDB*TAG_WIDTH  port k occupies bits [k*TAG_WIDTH +: TAG_WIDTH].
- cdb_value  in  NUM_CDB*DATA_WIDTH  port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- fu_valid  out  1  output stage holds an instruction.
- fu_ready  in  1  FU accepts.
- fu_op1/fu_op2/fu_op3  out  DATA_WIDTH  operands.
- fu_opcode  out  OP_WIDTH.
- fu_dest_tag  out  TAG_WIDTH.
- fu_dest_reg  out  5.

Behaviour:
- Reset (async): all busy and ready flags 0, age state cleared, fu_valid 0, all fu_* data outputs 0. disp_ready is 1 after reset.
- Allocation: lowest-index non-busy entry. disp_ready reflects registered busy only, so an entry freed by issue this cycle is not reusable until the next cycle.
- Dispatch accepted when disp_valid && disp_ready && !flush.
  - Entry written next edge with the given values and flags.
  - Same-cycle capture: for each source with rdy=0, if any valid CDB port tag matches, store that CDB value with rdy=1.
- Wakeup: for every busy entry and operand with rdy=0, a matching valid CDB port loads the value and sets rdy next edge.
  - If several ports carry the same tag, the lowest port index wins. Values are identical by contract; there is no assertion.
- Ready condition: entry busy && r1 && r2 && (r3 || NUM_SRC==2), evaluated on registered flags. An operand woken at edge N makes the entry eligible in cycle N+1.
- Select: oldest ready entry by dispatch order. Implement as an NUM_ENTRIES x NUM_ENTRIES age matrix; a newly dispatched entry is younger than all busy entries.
- Output stage: load when (!fu_valid || fu_ready) and a ready entry exists.
  - On load, copy fields to fu_* registers, set fu_valid=1 and clear that entry's busy in the same edge.
  - If fu_valid && fu_ready and nothing is ready, fu_valid drops to 0.
  - fu_* data holds stable while fu_valid && !fu_ready.
- Throughput: 1 issue per cycle. Minimum latency from dispatch with all operands ready to fu_valid=1 is 2 edges.
- Simultaneous events:
  - Dispatch and issue in the same cycle touch different entries, since the new entry is not ready until written.
  - Wakeup and issue of the same entry: the entry was already ready, so no conflict.
- Flush (synchronous, highest priority): next edge clears all busy, all ready flags, age state and fu_valid. Any dispatch and CDB capture in that cycle are discarded.
- Reset mid-operation: immediate return to reset state. No instruction survives.

Optional Feature:
- Macro RS_OCCUPANCY_EN.
- Defined: adds outputs occupancy [$clog2(NUM_ENTRIES+1)-1:0] (count of busy entries, registered, updated each edge with dispatch/issue/flush) and almost_full (occupancy >= NUM_ENTRIES-1).
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Dispatch A (rob 1, all rdy, op1=5, op2=7) with fu_ready=1 -> fu_valid=1 two edges later, fu_op1=5, fu_op2=7, fu_dest_tag=1.
- Dispatch B (rob 2, src1 tag 4 not ready), then C (rob 3, src1 tag 5 not ready); CDB port1 tag 5 val 0x55, next cycle port0 tag 4 val 0x44 -> C issues first with op1=0x55, then B with op1=0x44.
- Dual-CDB hit in the dispatch cycle: src1 tag 6 and src2 tag 7 not ready, cdb0={6,0x10}, cdb1={7,0x20} in the same cycle -> entry issues with op1=0x10, op2=0x20 without further CDB traffic.
- Fill with NUM_ENTRIES all-ready entries and hold fu_ready=0 -> disp_ready=0, fu_valid=1, outputs stable. Release fu_ready -> entries issue oldest-first, one per cycle.
- Flush asserted with 3 busy entries, fu_valid=1 and a simultaneous disp_valid -> next cycle fu_valid=0, disp_ready=1, no later issue of the old entries.
- NUM_SRC=2 build: src3_rdy=0 with an unmatched tag -> entry still issues once r1 and r2 are set.
